// File: rtl/secure_mem_arbiter_if.sv
// Bus bundle for secure_mem_arbiter: two requester lanes plus the memory port.
//   req/req_we/req_addr/req_wdata/lock_mask : requester side, into the arbiter
//   ack/err/rdata/busy                      : completion side, out of the arbiter
//   mem_rd_en/mem_wr_en/mem_addr/mem_wdata  : memory strobes, out of the arbiter
//   mem_rdata/mem_valid                     : registered memory response, into the arbiter
// slave = arbiter view, master = requester/memory environment view.
interface secure_mem_arbiter_if #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned LENGTH = 6
);
    localparam int unsigned AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic [1:0]         req;
    logic [1:0]         req_we;
    logic [2*AW-1:0]    req_addr;
    logic [2*WIDTH-1:0] req_wdata;
    logic [LENGTH-1:0]  lock_mask;
    logic [1:0]         ack;
    logic [1:0]         err;
    logic [WIDTH-1:0]   rdata;
    logic               busy;
    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [AW-1:0]      mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH-1:0]   mem_rdata;
    logic               mem_valid;

    modport slave (
        input  req, req_we, req_addr, req_wdata, lock_mask, mem_rdata, mem_valid,
        output ack, err, rdata, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, lock_mask, mem_rdata, mem_valid,
        input  ack, err, rdata, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/secure_mem_arbiter.sv
// Round-robin arbiter between a secure engine (lane 0) and a host (lane 1)
// in front of a single-port memory, with host write-lock and address checks.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : secure_mem_arbiter_if.slave (requests, completions, memory port)
// All outputs are registered; exactly one memory operation is in flight.
module secure_mem_arbiter #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned LENGTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    secure_mem_arbiter_if.slave  bus
);
    localparam int unsigned AW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned NP  = 1 << AW;
    localparam int unsigned CW  = 2;
    localparam int unsigned TMO = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q;
    logic             id_q;
    logic             we_q;
    logic             last_q;
    logic [CW-1:0]    tmo_q;
    logic [1:0]       ack_q;
    logic [1:0]       err_q;
    logic [WIDTH-1:0] rdata_q;
    logic             busy_q;
    logic             mem_rd_en_q;
    logic             mem_wr_en_q;
    logic [AW-1:0]    mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic             gnt_d;
    logic             we_d;
    logic [AW-1:0]    addr_d;
    logic [WIDTH-1:0] wdata_d;
    logic             reject_d;
    logic [NP-1:0]    lock_pad;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Pad lock_mask to the full address space so any address indexes safely.
    assign lock_pad = NP'(bus.lock_mask);

    // Grant selection: on a tie the lane not granted last wins.
    always_comb begin
        gnt_d    = 1'b0;
        we_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        reject_d = 1'b0;
        if (bus.req == 2'b11) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = bus.req[1];
        end
        we_d    = gnt_d ? bus.req_we[1] : bus.req_we[0];
        addr_d  = gnt_d ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        wdata_d = gnt_d ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
        // The secure engine bypasses the lock; only host writes are checked.
        reject_d = (32'(addr_d) >= LENGTH) || (gnt_d && we_d && lock_pad[addr_d]);
    end

    // Transaction FSM; pulse outputs default low and are set on state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            tmo_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        id_q   <= gnt_d;
                        we_q   <= we_d;
                        busy_q <= 1'b1;
                        if (reject_d) begin
                            state_q <= DONE;
                            ack_q   <= id_onehot(gnt_d);
                            err_q   <= id_onehot(gnt_d);
                        end else begin
                            state_q     <= ISSUE;
                            mem_addr_q  <= addr_d;
                            mem_rd_en_q <= ~we_d;
                            mem_wr_en_q <= we_d;
                            mem_wdata_q <= we_d ? wdata_d : '0;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state_q <= DONE;
                        ack_q   <= id_onehot(id_q);
                    end else begin
                        state_q <= WAIT;
                        tmo_q   <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mem_valid) begin
                        state_q <= DONE;
                        ack_q   <= id_onehot(id_q);
                        rdata_q <= bus.mem_rdata;
                    end else if (tmo_q == CW'(TMO - 1)) begin
                        state_q <= DONE;
                        ack_q   <= id_onehot(id_q);
                        err_q   <= id_onehot(id_q);
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    last_q  <= id_q;
                    tmo_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_secure_mem_arbiter.sv
// Self-checking bench for secure_mem_arbiter: a directed vector table of
// single-requester transactions plus hand-written tie and reset sequences.
`timescale 1ns/1ps
module tb_secure_mem_arbiter;
    localparam int unsigned WIDTH  = 256;
    localparam int unsigned LENGTH = 6;
    localparam int unsigned NB     = WIDTH / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    secure_mem_arbiter_if #(.WIDTH(WIDTH), .LENGTH(LENGTH)) bus ();
    secure_mem_arbiter #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: registered read data and valid one cycle after mem_rd_en.
    logic [WIDTH-1:0] mem [0:7];
    logic             hold_valid;
    logic             do_init;
    always @(posedge clk) begin
        if (do_init) begin
            for (int k = 0; k < 8; k++) mem[k] <= {NB{8'(8'h10 + k)}};
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_valid <= bus.mem_rd_en && !hold_valid;
        bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : '0;
    end

    function automatic logic [WIDTH-1:0] pat(input logic [7:0] b);
        return {NB{b}};
    endfunction

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait for an ack pulse, counting cycles and strobes; optionally scramble
    // the request inputs right after the grant edge.
    task automatic wait_ack(input bit scramble, output logic [1:0] a, output int n,
                            output int nrd, output int nwr);
        a = '0; n = 0; nrd = 0; nwr = 0;
        while (a == 2'b00 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_rd_en) nrd++;
            if (bus.mem_wr_en) nwr++;
            chk_i("strobe_excl", int'(bus.mem_rd_en && bus.mem_wr_en), 0);
            if (scramble && n == 1) begin
                bus.req_addr  = ~bus.req_addr;
                bus.req_wdata = ~bus.req_wdata;
                bus.req_we    = ~bus.req_we;
                bus.lock_mask = ~bus.lock_mask;
            end
            a = bus.ack;
        end
        if (a == 2'b00) $display("FAIL ack_timeout: got no ack within %0d cycles", n);
    endtask

    typedef struct {
        logic [1:0] req;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wbyte;
        logic [5:0] lock;
        logic       hold;
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        int         exp_lat;
        logic [7:0] exp_byte;
        int         exp_rd;
        int         exp_wr;
    } vec_t;

    vec_t vecs [14];

    logic [1:0] a;
    int n, nrd, nwr;

    initial begin
        //          req    we    addr  wbyte  lock       hold  ack    err    lat byte   rd wr
        vecs[0]  = '{2'b01, 1'b0, 3'd2, 8'h00, 6'b000000, 1'b0, 2'b01, 2'b00, 3, 8'h12, 1, 0};
        vecs[1]  = '{2'b10, 1'b0, 3'd5, 8'h00, 6'b000000, 1'b0, 2'b10, 2'b00, 3, 8'h15, 1, 0};
        vecs[2]  = '{2'b10, 1'b1, 3'd2, 8'h77, 6'b000100, 1'b0, 2'b10, 2'b10, 1, 8'h00, 0, 0};
        vecs[3]  = '{2'b01, 1'b1, 3'd2, 8'h3C, 6'b000100, 1'b0, 2'b01, 2'b00, 2, 8'h00, 0, 1};
        vecs[4]  = '{2'b10, 1'b0, 3'd2, 8'h00, 6'b000100, 1'b0, 2'b10, 2'b00, 3, 8'h3C, 1, 0};
        vecs[5]  = '{2'b10, 1'b1, 3'd4, 8'hA5, 6'b000000, 1'b0, 2'b10, 2'b00, 2, 8'h00, 0, 1};
        vecs[6]  = '{2'b10, 1'b0, 3'd4, 8'h00, 6'b000000, 1'b0, 2'b10, 2'b00, 3, 8'hA5, 1, 0};
        vecs[7]  = '{2'b10, 1'b0, 3'd6, 8'h00, 6'b000000, 1'b0, 2'b10, 2'b10, 1, 8'h00, 0, 0};
        vecs[8]  = '{2'b01, 1'b0, 3'd7, 8'h00, 6'b000000, 1'b0, 2'b01, 2'b01, 1, 8'h00, 0, 0};
        vecs[9]  = '{2'b01, 1'b1, 3'd6, 8'h99, 6'b000000, 1'b0, 2'b01, 2'b01, 1, 8'h00, 0, 0};
        vecs[10] = '{2'b01, 1'b0, 3'd1, 8'h00, 6'b000000, 1'b1, 2'b01, 2'b01, 6, 8'h00, 1, 0};
        vecs[11] = '{2'b10, 1'b1, 3'd0, 8'h66, 6'b000001, 1'b0, 2'b10, 2'b10, 1, 8'h00, 0, 0};
        vecs[12] = '{2'b01, 1'b1, 3'd0, 8'h5A, 6'b111111, 1'b0, 2'b01, 2'b00, 2, 8'h00, 0, 1};
        vecs[13] = '{2'b10, 1'b0, 3'd0, 8'h00, 6'b000000, 1'b0, 2'b10, 2'b00, 3, 8'h5A, 1, 0};

        rst           = 1'b0;
        do_init       = 1'b1;
        hold_valid    = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.lock_mask = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        do_init = 1'b0;
        chk_i("rst_ack", int'(bus.ack), 0);
        chk_i("rst_err", int'(bus.err), 0);
        chk_w("rst_rdata", bus.rdata, '0);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_i("rst_strobes", int'({bus.mem_rd_en, bus.mem_wr_en}), 0);
        chk_i("rst_mem_addr", int'(bus.mem_addr), 0);
        chk_w("rst_mem_wdata", bus.mem_wdata, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_i("idle_busy", int'(bus.busy), 0);

        // Tie: lane 0 first after reset; lane 0 re-requests, so lane 1 goes next
        bus.req_we   = 2'b00;
        bus.req_addr = {3'd3, 3'd1};
        bus.req      = 2'b11;
        wait_ack(1'b0, a, n, nrd, nwr);
        chk_i("tie1_ack", int'(a), 1);
        chk_i("tie1_lat", n, 3);
        chk_w("tie1_rdata", bus.rdata, pat(8'h11));
        wait_ack(1'b0, a, n, nrd, nwr);
        chk_i("tie2_ack", int'(a), 2);
        chk_i("tie2_lat", n, 4);
        chk_w("tie2_rdata", bus.rdata, pat(8'h13));
        bus.req = 2'b01;
        wait_ack(1'b0, a, n, nrd, nwr);
        chk_i("tie3_ack", int'(a), 1);
        chk_i("tie3_lat", n, 4);
        chk_w("tie3_rdata", bus.rdata, pat(8'h11));
        bus.req = 2'b00;
        @(posedge clk); #1;

        // Directed single-requester vectors
        for (int i = 0; i < 14; i++) begin
            bus.req_we    = {vecs[i].we, vecs[i].we};
            bus.req_addr  = {vecs[i].addr, vecs[i].addr};
            bus.req_wdata = {(2*NB){vecs[i].wbyte}};
            bus.lock_mask = vecs[i].lock;
            hold_valid    = vecs[i].hold;
            bus.req       = vecs[i].req;
            wait_ack(1'b1, a, n, nrd, nwr);
            bus.req = 2'b00;
            $display("vec %0d", i);
            chk_i("v_ack", int'(a), int'(vecs[i].exp_ack));
            chk_i("v_err", int'(bus.err), int'(vecs[i].exp_err));
            chk_w("v_rdata", bus.rdata, pat(vecs[i].exp_byte));
            chk_i("v_lat", n, vecs[i].exp_lat);
            chk_i("v_rd_strobes", nrd, vecs[i].exp_rd);
            chk_i("v_wr_strobes", nwr, vecs[i].exp_wr);
            @(posedge clk); #1;
            hold_valid = 1'b0;
            chk_i("v_ack_pulse", int'(bus.ack), 0);
            chk_i("v_busy_idle", int'(bus.busy), 0);
            chk_w("v_rdata_idle", bus.rdata, '0);
        end

        // Reset during WAIT aborts without ack; held request reruns afterwards
        bus.req_we   = 2'b00;
        bus.req_addr = {3'd3, 3'd3};
        bus.lock_mask = '0;
        bus.req      = 2'b10;
        @(posedge clk); #1;
        chk_i("mr_rd_en", int'(bus.mem_rd_en), 1);
        chk_i("mr_addr", int'(bus.mem_addr), 3);
        @(posedge clk); #1;
        chk_i("mr_busy_wait", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk_i("mr_ack", int'(bus.ack), 0);
        chk_i("mr_err", int'(bus.err), 0);
        chk_w("mr_rdata", bus.rdata, '0);
        chk_i("mr_busy", int'(bus.busy), 0);
        chk_i("mr_strobes", int'({bus.mem_rd_en, bus.mem_wr_en}), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_i("mr_no_ack", int'(bus.ack), 0);
        end
        rst = 1'b1;
        wait_ack(1'b0, a, n, nrd, nwr);
        bus.req = 2'b00;
        chk_i("mr_rerun_ack", int'(a), 2);
        chk_i("mr_rerun_lat", n, 3);
        chk_i("mr_rerun_err", int'(bus.err), 0);
        chk_w("mr_rerun_rdata", bus.rdata, pat(8'h13));
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
